tile_fetch_seq: RTL

- Per-8-pixel tile fetch sequencer for the character layer; sits directly upstream of the 2-plane left/right serializer.
- Reads tile code/attribute from VRAM, then the two bitplane bytes from graphics ROM.
- Presents serializer inputs: load strobe, plane bytes and flip select, plus a palette colour aligned with the serialized pixels.
- All activity gated by the pixel clock enable; one tile fetched per 8-pixel slot, one slot ahead of display.

---
 rtl/tile_fetch_seq.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/tile_fetch_seq.sv
// tile_fetch_seq: per-slot VRAM/graphics-ROM fetch sequencer feeding the 2-plane serializer.
// Optional build macro FLIPY_EN: honour vram_data[12] as a vertical tile flip.
module tile_fetch_seq #(
  parameter int unsigned COLS        = 32,
  parameter logic [2:0]  BLANK_COLOR = 3'd0
) (
  input  logic        clk,
  input  logic        n_clr,
  input  logic        pix_ce,
  input  logic [8:0]  hcnt,
  input  logic [7:0]  vcnt,
  input  logic        vblank,
  output logic [9:0]  vram_addr,
  input  logic [15:0] vram_data,
  output logic [13:0] gfx_addr,
  input  logic [15:0] gfx_data,
  output logic        shift_ld,
  output logic [7:0]  d1_out,
  output logic [7:0]  d2_out,
  output logic        sel,
  output logic [2:0]  color_out
);

  // The slot phase is taken straight from hcnt, so an hcnt jump simply resyncs the sequence.
  typedef enum logic [2:0] {
    FETCH_NT = 3'd0,
    WAIT_NT  = 3'd1,
    LATCH_NT = 3'd2,
    FETCH_PT = 3'd3,
    WAIT_PT  = 3'd4,
    LATCH_PT = 3'd5,
    PRE_LOAD = 3'd6,
    LOAD     = 3'd7
  } phase_t;

  localparam logic [6:0] COLS_LIM = (COLS > 64) ? 7'd64 : 7'(COLS);

  phase_t      ph;
  logic [5:0]  next_col;
  logic [2:0]  line;

  logic        slot_valid, slot_valid_d;
  logic [10:0] pend_code, pend_code_d;
  logic        pend_flipx, pend_flipx_d;
  logic [2:0]  pend_color, pend_color_d;
  logic [7:0]  hold_p0, hold_p0_d;
  logic [7:0]  hold_p1, hold_p1_d;
  logic        hold_sel, hold_sel_d;
  logic [9:0]  vram_addr_d;
  logic [13:0] gfx_addr_d;
  logic        shift_ld_d;
  logic [2:0]  color_out_d;

  assign ph       = phase_t'(hcnt[2:0]);
  assign next_col = hcnt[8:3] + 6'd1;

`ifdef FLIPY_EN
  logic pend_flipy;

  always_ff @(posedge clk or negedge n_clr) begin
    if (!n_clr)                       pend_flipy <= 1'b0;
    else if (pix_ce && ph == LATCH_NT) pend_flipy <= vram_data[12];
  end

  assign line = pend_flipy ? ~vcnt[2:0] : vcnt[2:0];
`else
  logic unused_flipy;
  assign unused_flipy = vram_data[12];
  assign line         = vcnt[2:0];
`endif

  always_comb begin
    slot_valid_d = slot_valid;
    pend_code_d  = pend_code;
    pend_flipx_d = pend_flipx;
    pend_color_d = pend_color;
    hold_p0_d    = hold_p0;
    hold_p1_d    = hold_p1;
    hold_sel_d   = hold_sel;
    vram_addr_d  = vram_addr;
    gfx_addr_d   = gfx_addr;
    shift_ld_d   = shift_ld;
    color_out_d  = color_out;
    if (pix_ce) begin
      // Registered strobe: low for exactly the ph7 interval, whatever the ce rate.
      shift_ld_d = (ph != PRE_LOAD);
      case (ph)
        FETCH_NT: begin
          vram_addr_d  = {vcnt[7:3], next_col[4:0]};
          slot_valid_d = ({1'b0, next_col} < COLS_LIM) & ~vblank;
        end
        LATCH_NT: begin
          pend_code_d  = vram_data[10:0];
          pend_flipx_d = slot_valid & vram_data[11];
          pend_color_d = slot_valid ? vram_data[15:13] : BLANK_COLOR;
        end
        FETCH_PT: gfx_addr_d = {pend_code, line};
        LATCH_PT: begin
          hold_p0_d  = slot_valid ? gfx_data[7:0]  : 8'h00;
          hold_p1_d  = slot_valid ? gfx_data[15:8] : 8'h00;
          hold_sel_d = pend_flipx;
        end
        LOAD:     color_out_d = pend_color;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_clr) begin
    if (!n_clr) begin
      slot_valid <= 1'b0;
      pend_code  <= '0;
      pend_flipx <= 1'b0;
      pend_color <= BLANK_COLOR;
      hold_p0    <= '0;
      hold_p1    <= '0;
      hold_sel   <= 1'b0;
      vram_addr  <= '0;
      gfx_addr   <= '0;
      shift_ld   <= 1'b1;
      color_out  <= BLANK_COLOR;
    end else begin
      slot_valid <= slot_valid_d;
      pend_code  <= pend_code_d;
      pend_flipx <= pend_flipx_d;
      pend_color <= pend_color_d;
      hold_p0    <= hold_p0_d;
      hold_p1    <= hold_p1_d;
      hold_sel   <= hold_sel_d;
      vram_addr  <= vram_addr_d;
      gfx_addr   <= gfx_addr_d;
      shift_ld   <= shift_ld_d;
      color_out  <= color_out_d;
    end
  end

  assign d1_out = hold_p0;
  assign d2_out = hold_p1;
  assign sel    = hold_sel;

endmodule
